fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the address and instruction width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which sets the PC value loaded on reset.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The ports SHALL be, in order:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  WIDTH  byte address to instruction memory; the memory read is combinational with zero latency.
- imem_data  input  WIDTH  instruction word returned for imem_addr in the same cycle.
- redirect_valid  input  1  branch/jump redirect request.
- redirect_pc  input  WIDTH  redirect target address.
- dec_valid  output  1  the decode-side entry is valid.
- dec_ready  input  1  decode accepts the entry.
- dec_instr  output  WIDTH  instruction at the buffer head.
- dec_pc  output  WIDTH  PC of the buffer head.
- misalign_err  output  1  one-cycle pulse for a misaligned redirect target.

Function
REQ-005 The block SHALL hold a PC register; imem_addr SHALL equal the PC combinationally.
REQ-006 The block SHALL contain a 2-entry FIFO of {pc, instr} pairs with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-007 A pop SHALL occur on a rising edge when dec_valid=1, dec_ready=1 and redirect_valid=0.
REQ-008 A push SHALL occur on a rising edge when redirect_valid=0 and either count<2 or a pop occurs in the same cycle. The push SHALL write {PC, imem_data} at the tail, and the PC SHALL advance by 4 on that edge.
REQ-009 When count=2 and no pop occurs, the block SHALL stall: PC held, no push, FIFO contents unchanged.
REQ-010 The count SHALL update as count + push − pop; a simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-011 dec_valid SHALL be 1 if and only if count>0; dec_instr and dec_pc SHALL be driven from the head entry.
REQ-012 When count=0, dec_instr and dec_pc SHALL be 0.
REQ-013 When redirect_valid=1, on that edge the block SHALL:
- flush the FIFO to count 0;
- load PC with {redirect_pc[WIDTH-1:2], 2'b00};
- perform no push;
- perform no pop.
REQ-014 An entry presented during a redirect cycle SHALL be discarded even if dec_ready=1; the decode stage SHALL treat it as not accepted.
REQ-015 On the edge following a redirect, the first push SHALL carry the redirect target, and dec_valid SHALL rise at that edge.
REQ-016 misalign_err SHALL be registered. It SHALL be 1 for exactly the cycle after a redirect edge where redirect_pc[1:0]≠0, and 0 otherwise.
REQ-017 The PC SHALL wrap modulo 2^WIDTH (e.g. 32'hFFFF_FFFC + 4 = 32'h0000_0000) with no error indication.
REQ-018 Latency from a PC value appearing on imem_addr to its entry being visible on dec_valid/dec_instr SHALL be exactly one clock edge, provided no stall and no redirect occur.
REQ-019 Sustained throughput SHALL be one instruction per cycle when dec_ready is held at 1.
REQ-020 redirect_valid SHALL have priority over push, pop and stall in the same cycle.

Reset
REQ-021 While rst_n=0, asynchronously:
- PC = RESET_PC;
- imem_addr = RESET_PC;
- count = 0 and dec_valid = 0;
- dec_instr = 0 and dec_pc = 0;
- misalign_err = 0;
- all FIFO entries = 0.
REQ-022 An assertion of rst_n=0 mid-stall or mid-redirect SHALL discard all state.
REQ-023 After rst_n deasserts, the first push SHALL occur on the first rising edge, fetching RESET_PC.

Verification
REQ-024 Reset release with dec_ready=1 and memory word = 0x00100000+addr: dec_pc SHALL be 0, 4, 8, … on consecutive cycles with dec_valid=1 from the first edge.
REQ-025 Backpressure: hold dec_ready=0 for 5 cycles after reset. The FIFO SHALL hold PC 0 and 4, imem_addr SHALL stay at 8, and on release the outputs SHALL be 0, 4, 8 with no duplicate and no loss.
REQ-026 Redirect to 0x100 while count=2 and dec_ready=1: the next cycle SHALL show dec_valid=1 with dec_pc=0x100, with no old entry popped or emitted after the redirect.
REQ-027 Redirect to 0x102: PC SHALL load 0x100, misalign_err SHALL pulse high for one cycle, and the next dec_pc SHALL be 0x100.
REQ-028 With PC forced via redirect to 0xFFFF_FFF8 and dec_ready=1: dec_pc SHALL be 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in sequence.
REQ-029 Assert rst_n=0 asynchronously between edges while FULL: dec_valid and misalign_err SHALL drop to 0 immediately, and imem_addr SHALL become RESET_PC immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, zero-latency memory lookup and a
// 2-entry {pc, instr} buffer feeding decode, with redirect flush.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [WIDTH-1:0] dec_instr,
    output logic [WIDTH-1:0] dec_pc,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] e0_pc_q, e0_pc_d, e0_instr_q, e0_instr_d;
    logic [WIDTH-1:0] e1_pc_q, e1_pc_d, e1_instr_q, e1_instr_d;
    logic             misalign_q, misalign_d;
    logic             pop, push;

    // State and buffer registers; entry 0 is always the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            pc_q       <= RESET_PC;
            e0_pc_q    <= '0;
            e0_instr_q <= '0;
            e1_pc_q    <= '0;
            e1_instr_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            e0_pc_q    <= e0_pc_d;
            e0_instr_q <= e0_instr_d;
            e1_pc_q    <= e1_pc_d;
            e1_instr_q <= e1_instr_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state: redirect flushes and clears entries so an empty head reads 0.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        e0_pc_d    = e0_pc_q;
        e0_instr_d = e0_instr_q;
        e1_pc_d    = e1_pc_q;
        e1_instr_d = e1_instr_q;
        misalign_d = 1'b0;

        pop  = (state_q != EMPTY) && dec_ready && !redirect_valid;
        push = !redirect_valid && ((state_q != FULL) || pop);

        if (redirect_valid) begin
            state_d    = EMPTY;
            pc_d       = {redirect_pc[WIDTH-1:2], 2'b00};
            e0_pc_d    = '0;
            e0_instr_d = '0;
            e1_pc_d    = '0;
            e1_instr_d = '0;
            misalign_d = |redirect_pc[1:0];
        end else if (push) begin
            pc_d = pc_q + WIDTH'(4);
            unique case (state_q)
                EMPTY: begin
                    e0_pc_d    = pc_q;
                    e0_instr_d = imem_data;
                    state_d    = ONE;
                end
                ONE: begin
                    if (pop) begin
                        e0_pc_d    = pc_q;
                        e0_instr_d = imem_data;
                    end else begin
                        e1_pc_d    = pc_q;
                        e1_instr_d = imem_data;
                        state_d    = FULL;
                    end
                end
                FULL: begin
                    e0_pc_d    = e1_pc_q;
                    e0_instr_d = e1_instr_q;
                    e1_pc_d    = pc_q;
                    e1_instr_d = imem_data;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign imem_addr    = pc_q;
    assign dec_valid    = (state_q != EMPTY);
    assign dec_pc       = e0_pc_q;
    assign dec_instr    = e0_instr_q;
    assign misalign_err = misalign_q;

endmodule
